// File: rtl/dmem_ctrl.sv
// Data-memory controller for the 32I MEM stage: fixed-latency byte-addressable RAM
// with alignment/range fault detection and right-aligned load data.
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mreq,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [1:0]  access_size,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        ready,
    output logic        fault,
    output logic        stall
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [31:0] addr_reg;
    logic        write_reg;
    logic [1:0]  size_reg;
    logic [31:0] wdata_reg;
    logic        ready_reg;
    logic        fault_reg;
    logic [31:0] rd_data_reg;

    logic        accept;
    logic        complete;
    logic        bad_access;
    logic [3:0]  lane_we;
    logic [31:0] word_rd;
    logic [31:0] word_shifted;
    logic [31:0] load_next;

    assign accept   = (state_reg == IDLE) && mreq;
    assign complete = (state_reg == BUSY) && (cnt_reg == 4'd0);

    always_comb begin
        bad_access = (size_reg == 2'b11)
                  || ((size_reg == SZ_HALF) && addr_reg[0])
                  || ((size_reg == SZ_WORD) && (addr_reg[1:0] != 2'b00))
                  || (addr_reg[31:AW+2] != '0);
    end

    // One RAM per byte lane so each store only touches the lanes it selects.
    // The word is read at the accept edge; no store can intervene before completion.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);

            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] lane_rd_reg;
            logic       lane_sel;
            logic [7:0] lane_wd;

            always_comb begin
                lane_sel = 1'b0;
                lane_wd  = 8'h00;
                case (size_reg)
                    SZ_BYTE: begin
                        lane_sel = (addr_reg[1:0] == LANE);
                        lane_wd  = wdata_reg[7:0];
                    end
                    SZ_HALF: begin
                        lane_sel = (addr_reg[1] == LANE[1]);
                        lane_wd  = LANE[0] ? wdata_reg[15:8] : wdata_reg[7:0];
                    end
                    SZ_WORD: begin
                        lane_sel = 1'b1;
                        lane_wd  = wdata_reg[8*gi +: 8];
                    end
                    default: begin
                        lane_sel = 1'b0;
                        lane_wd  = 8'h00;
                    end
                endcase
            end

            assign lane_we[gi] = complete && write_reg && !bad_access && lane_sel;

            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    mem[addr_reg[AW+1:2]] <= lane_wd;
                end
                if (accept) begin
                    lane_rd_reg <= mem[addr[AW+1:2]];
                end
            end

            assign word_rd[8*gi +: 8] = lane_rd_reg;
        end
    endgenerate

    always_comb begin
        word_shifted = word_rd >> {addr_reg[1:0], 3'b000};
        case (size_reg)
            SZ_BYTE: load_next = {24'h0, word_shifted[7:0]};
            SZ_HALF: load_next = {16'h0, word_shifted[15:0]};
            default: load_next = word_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            addr_reg    <= 32'h0;
            write_reg   <= 1'b0;
            size_reg    <= 2'b00;
            wdata_reg   <= 32'h0;
            ready_reg   <= 1'b0;
            fault_reg   <= 1'b0;
            rd_data_reg <= 32'h0;
        end else begin
            ready_reg <= 1'b0;
            fault_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (mreq) begin
                        addr_reg  <= addr;
                        write_reg <= write;
                        size_reg  <= access_size;
                        wdata_reg <= wr_data;
                        cnt_reg   <= 4'(LATENCY - 1);
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg == 4'd0) begin
                        ready_reg   <= 1'b1;
                        fault_reg   <= bad_access;
                        rd_data_reg <= (bad_access || write_reg) ? 32'h0 : load_next;
                        state_reg   <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rd_data = rd_data_reg;
    assign ready   = ready_reg;
    assign fault   = fault_reg;
    assign stall   = mreq & ~ready_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a LATENCY=2 instance driven from a vector table
// plus reset/back-to-back sequences, and a LATENCY=1 instance for the short-latency build.
module tb_dmem_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        mreq_a, write_a, mreq_b, write_b;
    logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
    logic [1:0]  size_a, size_b;
    logic [31:0] rd_a, rd_b;
    logic        ready_a, fault_a, stall_a, ready_b, fault_b, stall_b;

    dmem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .mreq(mreq_a), .write(write_a), .addr(addr_a),
        .access_size(size_a), .wr_data(wdata_a), .rd_data(rd_a), .ready(ready_a),
        .fault(fault_a), .stall(stall_a)
    );

    dmem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .mreq(mreq_b), .write(write_b), .addr(addr_b),
        .access_size(size_b), .wr_data(wdata_b), .rd_data(rd_b), .ready(ready_b),
        .fault(fault_b), .stall(stall_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [1:0]  sz;
        logic [31:0] wd;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          exp_flt;
        string       name;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit m, input bit wr, input logic [31:0] a,
                         input logic [1:0] sz, input logic [31:0] wd);
        if (sel) begin
            mreq_b = m; write_b = wr; addr_b = a; size_b = sz; wdata_b = wd;
        end else begin
            mreq_a = m; write_a = wr; addr_a = a; size_a = sz; wdata_a = wd;
        end
    endtask

    function automatic logic cur_ready(input bit sel);
        return sel ? ready_b : ready_a;
    endfunction
    function automatic logic cur_fault(input bit sel);
        return sel ? fault_b : fault_a;
    endfunction
    function automatic logic cur_stall(input bit sel);
        return sel ? stall_b : stall_a;
    endfunction
    function automatic logic [31:0] cur_rd(input bit sel);
        return sel ? rd_b : rd_a;
    endfunction

    // One access: checks latency from accept, stall cycles, fault, data, and one-cycle pulses.
    task automatic access(input bit sel, input bit wr, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] wd, input int exp_lat, input bit chk_rd,
                          input logic [31:0] exp_rd, input bit exp_flt, input string name);
        int k;
        int stalls;
        logic [31:0] got_rd;
        @(negedge clk);
        drive(sel, 1'b1, wr, a, sz, wd);
        #1;
        chk({name, " stall_at_req"}, 32'(cur_stall(sel)), 32'd1);
        k = 0;
        stalls = 0;
        do begin
            @(negedge clk);
            k++;
            if (!cur_ready(sel)) stalls += int'(cur_stall(sel));
        end while (!cur_ready(sel) && k < 40);
        if (!cur_ready(sel)) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s timeout: no ready within 40 cycles, required within %0d", name, exp_lat + 1);
            drive(sel, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        end else begin
            chk({name, " latency"}, 32'(k - 1), 32'(exp_lat));
            chk({name, " stall_cycles"}, 32'(stalls), 32'(exp_lat));
            chk({name, " stall_in_ready"}, 32'(cur_stall(sel)), 32'd0);
            chk({name, " fault"}, 32'(cur_fault(sel)), 32'(exp_flt));
            got_rd = cur_rd(sel);
            if (chk_rd) chk({name, " rd_data"}, got_rd, exp_rd);
            drive(sel, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
            @(negedge clk);
            chk({name, " ready_drop"}, 32'(cur_ready(sel)), 32'd0);
            chk({name, " fault_drop"}, 32'(cur_fault(sel)), 32'd0);
            chk({name, " rd_hold"}, cur_rd(sel), got_rd);
        end
        $display("access %-10s sel=%0d wr=%0d addr=0x%08h size=%0d -> lat=%0d rd=0x%08h",
                 name, sel, wr, a, sz, k - 1, got_rd);
    endtask

    logic [31:0] bb_addr [3];
    logic [1:0]  bb_size [3];
    logic [31:0] bb_exp  [3];

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0040, 2'b10, 32'h1234_5678, 1'b0, 32'h0,         1'b0, "st_w40"};
        vecs[1]  = '{1'b0, 32'h0000_0040, 2'b10, 32'h0,         1'b1, 32'h1234_5678, 1'b0, "ld_w40"};
        vecs[2]  = '{1'b1, 32'h0000_0000, 2'b10, 32'h0BAD_F00D, 1'b0, 32'h0,         1'b0, "st_w00"};
        vecs[3]  = '{1'b1, 32'h0000_0020, 2'b10, 32'hAABB_CCDD, 1'b0, 32'h0,         1'b0, "st_w20"};
        vecs[4]  = '{1'b1, 32'h0000_0022, 2'b00, 32'hFFFF_FF11, 1'b0, 32'h0,         1'b0, "st_b22"};
        vecs[5]  = '{1'b1, 32'h0000_0020, 2'b01, 32'hFFFF_5566, 1'b0, 32'h0,         1'b0, "st_h20"};
        vecs[6]  = '{1'b0, 32'h0000_0020, 2'b10, 32'h0,         1'b1, 32'hAA11_5566, 1'b0, "ld_w20"};
        vecs[7]  = '{1'b0, 32'h0000_0023, 2'b00, 32'h0,         1'b1, 32'h0000_00AA, 1'b0, "ld_b23"};
        vecs[8]  = '{1'b0, 32'h0000_0022, 2'b01, 32'h0,         1'b1, 32'h0000_AA11, 1'b0, "ld_h22"};
        vecs[9]  = '{1'b0, 32'h0000_0021, 2'b00, 32'h0,         1'b1, 32'h0000_0055, 1'b0, "ld_b21"};
        vecs[10] = '{1'b0, 32'h0000_0020, 2'b01, 32'h0,         1'b1, 32'h0000_5566, 1'b0, "ld_h20"};
        vecs[11] = '{1'b1, 32'h0000_0021, 2'b01, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1, "flt_h21"};
        vecs[12] = '{1'b1, 32'h0000_0022, 2'b10, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1, "flt_w22"};
        vecs[13] = '{1'b1, 32'h0000_0020, 2'b11, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1, "flt_sz3"};
        vecs[14] = '{1'b1, 32'h0000_1000, 2'b10, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1, "flt_range"};
        vecs[15] = '{1'b0, 32'h0000_1000, 2'b10, 32'h0,         1'b1, 32'h0,         1'b1, "flt_ldrng"};
        vecs[16] = '{1'b0, 32'h0000_0020, 2'b10, 32'h0,         1'b1, 32'hAA11_5566, 1'b0, "ld_w20_b"};
        vecs[17] = '{1'b0, 32'h0000_0000, 2'b10, 32'h0,         1'b1, 32'h0BAD_F00D, 1'b0, "ld_w00"};

        bb_addr = '{32'h40, 32'h20, 32'h23};
        bb_size = '{2'b10, 2'b10, 2'b00};
        bb_exp  = '{32'h1234_5678, 32'hAA11_5566, 32'h0000_00AA};

        drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst ready", 32'(ready_a), 32'd0);
        chk("rst fault", 32'(fault_a), 32'd0);
        chk("rst rd_data", rd_a, 32'h0);
        chk("rst stall", 32'(stall_a), 32'd0);
        rst_n = 1'b1;

        // Reset aborting a store mid-BUSY
        access(1'b0, 1'b1, 32'h10, 2'b10, 32'hCAFE_F00D, 2, 1'b0, 32'h0, 1'b0, "st_w10");
        access(1'b0, 1'b0, 32'h10, 2'b10, 32'h0, 2, 1'b1, 32'hCAFE_F00D, 1'b0, "ld_w10");
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h10, 2'b10, 32'hDEAD_BEEF);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        #1;
        chk("abort ready", 32'(ready_a), 32'd0);
        chk("abort fault", 32'(fault_a), 32'd0);
        chk("abort rd_data", rd_a, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort no_ready", 32'(ready_a), 32'd0);
        end
        $display("abort store 0x10 by reset mid-BUSY");
        access(1'b0, 1'b0, 32'h10, 2'b10, 32'h0, 2, 1'b1, 32'hCAFE_F00D, 1'b0, "ld_w10_rst");

        // Table-driven vectors on the LATENCY=2 instance
        for (int i = 0; i < 18; i++) begin
            access(1'b0, vecs[i].wr, vecs[i].a, vecs[i].sz, vecs[i].wd, 2,
                   vecs[i].chk_rd, vecs[i].exp_rd, vecs[i].exp_flt, vecs[i].name);
        end

        // Back-to-back loads with mreq held; bundle changes in each ready cycle
        begin
            int k;
            int pulses;
            int last;
            k = 0;
            pulses = 0;
            last = 0;
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b0, bb_addr[0], bb_size[0], 32'h0);
            while (pulses < 3 && k < 60) begin
                @(negedge clk);
                k++;
                if (ready_a) begin
                    chk("b2b rd_data", rd_a, bb_exp[pulses]);
                    chk("b2b fault", 32'(fault_a), 32'd0);
                    if (pulses == 0) chk("b2b first", 32'(k), 32'd3);
                    else chk("b2b spacing", 32'(k - last), 32'd3);
                    $display("b2b pulse %0d at cycle %0d rd=0x%08h", pulses, k, rd_a);
                    last = k;
                    pulses++;
                    if (pulses < 3) drive(1'b0, 1'b1, 1'b0, bb_addr[pulses], bb_size[pulses], 32'h0);
                    else drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
                end
            end
            if (pulses < 3) begin
                n_vec++;
                n_bad++;
                $display("FAIL b2b timeout: got %0d pulses, required 3", pulses);
                drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
            end
        end

        // LATENCY=1 instance
        access(1'b1, 1'b1, 32'h40, 2'b10, 32'h1234_5678, 1, 1'b0, 32'h0, 1'b0, "l1_st_w40");
        access(1'b1, 1'b0, 32'h40, 2'b10, 32'h0, 1, 1'b1, 32'h1234_5678, 1'b0, "l1_ld_w40");
        access(1'b1, 1'b0, 32'h41, 2'b01, 32'h0, 1, 1'b1, 32'h0, 1'b1, "l1_flt_h41");
        access(1'b1, 1'b0, 32'h42, 2'b01, 32'h0, 1, 1'b1, 32'h0000_1234, 1'b0, "l1_ld_h42");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion before 500000");
        $fatal(1);
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller sitting directly downstream of the MEM stage in the 32I pipeline. It accepts the MEM stage's request bundle (mreq, write, addr, access_size, wr_data) and services it against an internal byte-addressable RAM with a configurable fixed latency. It returns right-aligned read data for the MEM stage's sign/zero extension, plus ready/stall/fault status for the hazard unit. Misaligned and out-of-range accesses are detected and never modify memory.

## Interface
- DEPTH_WORDS, 1024: RAM size in 32-bit words; power of two.
- LATENCY, 2: edges from request acceptance to completion; legal range 1..15.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mreq  input  1  request valid; held high with stable bundle until ready.
- write  input  1  1 = store, 0 = load.
- addr  input  32  byte address.
- access_size  input  2  `BYTE=2'b00, `HALF=2'b01, `WORD=2'b10; 2'b11 illegal.
- wr_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rd_data  output  32  load data, right-aligned, upper bits zero; registered.
- ready  output  1  one-cycle completion pulse; registered.
- fault  output  1  qualifies ready: access rejected; registered.
- stall  output  1  combinational: mreq & ~ready.

## Operation
- FSM states: IDLE, BUSY.
- IDLE: if mreq=1, capture addr/write/size/wr_data, load counter with LATENCY-1, go BUSY; else stay.
- BUSY: counter decrements each edge; on the edge where the counter is 0, complete the access, set ready=1 for the next cycle, return to IDLE.
- In the cycle ready=1 the FSM is IDLE; a held mreq in that cycle is treated as a new request (the pipeline advances on ready, so mreq then belongs to the next instruction). Back-to-back throughput: one access per LATENCY+1 cycles.
- Fault conditions, checked on captured values: size 2'b11; HALF with addr[0]=1; WORD with addr[1:0]!=0; addr >= DEPTH_WORDS*4. On fault: no RAM write, rd_data=0, fault=1 with ready.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; byte lane = addr[1:0].
- Store: BYTE writes lane addr[1:0] with wr_data[7:0]; HALF writes lanes {addr[1],0} and {addr[1],1} with wr_data[15:0], little-endian; WORD writes all four lanes. Other lanes are unchanged.
- Load: selected lanes are shifted down to bit 0 and upper bits zero-filled. Extension is owned upstream.
- Loads have no side effects; a faulting load leaves the RAM unchanged.
- RAM contents are not reset and are undefined until written (the bench preloads via hierarchical access or stores).

## Timing
- Reset (rst_n=0, any time): state=IDLE, ready=0, fault=0, rd_data=0, counter=0. Reset mid-BUSY aborts the access with no RAM write and no ready.
- Accept edge A (IDLE, mreq=1). The RAM write and rd_data/fault update occur at edge A+LATENCY, and ready is high in the cycle following that edge.
  - LATENCY=1: ready in the cycle after A.
  - LATENCY=2: ready two cycles after A.
- ready, fault, rd_data hold their values for exactly one cycle. After that, ready=0 and fault=0, and rd_data holds its last value until the next completion.
- stall is high from the cycle mreq rises until ready, excluding the ready cycle.
- A mreq deassertion while BUSY is a protocol violation. The access still completes.

## Test plan
- Reset: rst_n low mid-BUSY with store 0xDEADBEEF to 0x10 -> no ready pulse; ready=0, fault=0, rd_data=0; a later load of 0x10 returns the prior contents.
- Word round trip, LATENCY=2: store WORD 0x12345678 to 0x40, then load WORD 0x40 -> rd_data=0x12345678; ready exactly 2 cycles after each accept; stall high for 2 cycles per access.
- Byte/half lanes: store WORD 0xAABBCCDD to 0x20, store BYTE 0x11 to 0x22, store HALF 0x5566 to 0x20; load WORD 0x20 -> 0xAA115566; load BYTE 0x23 -> 0x000000AA; load HALF 0x22 -> 0x0000AA11.
- Faults: HALF to 0x21, WORD to 0x22, size 2'b11, WORD to DEPTH_WORDS*4 -> each gives ready=1, fault=1, rd_data=0; memory at the affected words is unchanged.
- Back-to-back: mreq held high across 3 consecutive loads with the bundle changing in each ready cycle -> 3 ready pulses spaced LATENCY+1 cycles apart, each returning the correct data.
- LATENCY=1 build: repeat the word round trip -> ready one cycle after accept; stall high for 1 cycle.
